// File: rtl/memory_responder_if.sv
// memory_responder_if: cache-side bus of the two-port memory responder.
// Port 1 (fetch): readM1, address1 -> data1, ack1.
// Port 2 (load/store): readM2, writeM2, address2 -> ack2, data2_oe.
// The bidirectional data2 bus is a module-level inout. data2_oe tells the cache side
// when the responder is driving it.
interface memory_responder_if #(
  parameter int unsigned WORD_SIZE = 16
) ();
  logic                 readM1;
  logic [WORD_SIZE-1:0] address1;
  logic [WORD_SIZE-1:0] data1;
  logic                 ack1;
  logic                 readM2;
  logic                 writeM2;
  logic [WORD_SIZE-1:0] address2;
  logic                 ack2;
  logic                 data2_oe;

  modport master (
    output readM1, address1, readM2, writeM2, address2,
    input  data1, ack1, ack2, data2_oe
  );

  modport slave (
    input  readM1, address1, readM2, writeM2, address2,
    output data1, ack1, ack2, data2_oe
  );
endinterface

// File: rtl/memory_responder.sv
// memory_responder: fixed-latency main-memory stand-in serving an instruction-fetch port
// (port 1, read only) and a data port (port 2, read/write) over one shared word array.
// Each port runs its own IDLE/BUSY/DONE machine. A request answers LATENCY rising edges
// after it is first accepted.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset (array contents are kept)
//   bus    memory_responder_if slave modport (requests, addresses, data1, acks, data2_oe)
//   data2  port-2 data: write data in, read data out while data2_oe is high, else high-Z
// Only the low ADDR_BITS address bits select a word (ADDR_BITS must be < WORD_SIZE).
module memory_responder #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  memory_responder_if.slave    bus,
  inout  wire  [WORD_SIZE-1:0] data2
);
  localparam int unsigned Depth   = 2 ** ADDR_BITS;
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  logic [WORD_SIZE-1:0] mem [Depth];

  logic [ADDR_BITS-1:0] addr1_in, addr2_in;
  logic                 unused_addr;
  assign addr1_in    = bus.address1[ADDR_BITS-1:0];
  assign addr2_in    = bus.address2[ADDR_BITS-1:0];
  assign unused_addr = ^{bus.address1[WORD_SIZE-1:ADDR_BITS],
                         bus.address2[WORD_SIZE-1:ADDR_BITS]};

  // Port 1: instruction fetch
  state_e               st1_q;
  logic [3:0]           cnt1_q;
  logic [ADDR_BITS-1:0] addr1_q;
  logic [WORD_SIZE-1:0] data1_q;
  logic                 ack1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st1_q   <= StIdle;
      cnt1_q  <= '0;
      addr1_q <= '0;
      data1_q <= '0;
      ack1_q  <= 1'b0;
    end else begin
      ack1_q <= 1'b0;
      if (!bus.readM1) begin
        st1_q <= StIdle;
      end else if (st1_q == StIdle || addr1_in != addr1_q) begin
        // New request, or address moved under an outstanding one: restart.
        st1_q   <= StBusy;
        addr1_q <= addr1_in;
        cnt1_q  <= CntLoad;
      end else if (st1_q == StBusy) begin
        if (cnt1_q != '0) begin
          cnt1_q <= cnt1_q - 4'd1;
        end else begin
          st1_q   <= StDone;
          data1_q <= mem[addr1_q];
          ack1_q  <= 1'b1;
        end
      end
    end
  end

  // Port 2: data load/store; op2_q is 1 for a write
  state_e               st2_q;
  logic [3:0]           cnt2_q;
  logic [ADDR_BITS-1:0] addr2_q;
  logic                 op2_q;
  logic [WORD_SIZE-1:0] wdata2_q;
  logic [WORD_SIZE-1:0] data2_q;
  logic                 ack2_q;
  logic                 req2, op2_in, hit2, wr_commit, data2_oe;

  assign req2      = bus.readM2 | bus.writeM2;
  assign op2_in    = bus.writeM2;  // write wins when both requests are high
  assign hit2      = (addr2_in == addr2_q) && (op2_in == op2_q);
  assign wr_commit = (st2_q == StBusy) && req2 && hit2 && (cnt2_q == '0) && op2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st2_q    <= StIdle;
      cnt2_q   <= '0;
      addr2_q  <= '0;
      op2_q    <= 1'b0;
      wdata2_q <= '0;
      data2_q  <= '0;
      ack2_q   <= 1'b0;
    end else begin
      ack2_q <= 1'b0;
      if (!req2) begin
        st2_q <= StIdle;
      end else if (st2_q == StIdle || !hit2) begin
        st2_q   <= StBusy;
        addr2_q <= addr2_in;
        op2_q   <= op2_in;
        cnt2_q  <= CntLoad;
        if (op2_in) wdata2_q <= data2;
      end else if (st2_q == StBusy) begin
        if (cnt2_q != '0) begin
          cnt2_q <= cnt2_q - 4'd1;
        end else begin
          st2_q  <= StDone;
          ack2_q <= 1'b1;
          if (!op2_q) data2_q <= mem[addr2_q];
        end
      end
    end
  end

  // No reset on the array: contents survive reset. The FSM resets to IDLE asynchronously,
  // so an in-flight write can never reach this enable after reset.
  // Port 1 reads the old word on a same-edge collision (nonblocking read-before-write).
  always_ff @(posedge clk) begin
    if (wr_commit) mem[addr2_q] <= wdata2_q;
  end

  // !writeM2 keeps the responder off the bus on the edge a read turns into a write.
  assign data2_oe = (st2_q == StDone) && !op2_q && bus.readM2 && !bus.writeM2;
  assign data2    = data2_oe ? data2_q : 'z;

  assign bus.data1    = data1_q;
  assign bus.ack1     = ack1_q;
  assign bus.ack2     = ack2_q;
  assign bus.data2_oe = data2_oe;
endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: table-driven transactions, directed corner sequences and
// randomized traffic, all scored against an edge-counting model of the two ports.
module tb_memory_responder;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] tb_wdata;
  wire  [15:0] data2;

  always #5 clk = ~clk;

  memory_responder_if #(.WORD_SIZE(16)) bus ();

  assign data2 = bus.writeM2 ? tb_wdata : 'z;

  memory_responder #(
    .WORD_SIZE(16),
    .ADDR_BITS(8),
    .LATENCY  (LAT),
    .INIT_FILE("")
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .data2(data2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each port remembers what it accepted and how many edges ago.
  logic [15:0] mmem [256];
  bit          m1_act, m1_done, m1_ack;
  logic [7:0]  m1_addr;
  int          m1_age;
  logic [15:0] m1_data;
  bit          m2_act, m2_done, m2_ack, m2_wr;
  logic [7:0]  m2_addr;
  int          m2_age;
  logic [15:0] m2_data, m2_wdata;

  function automatic void model_reset();
    m1_act = 0; m1_done = 0; m1_ack = 0; m1_age = 0; m1_data = '0; m1_addr = '0;
    m2_act = 0; m2_done = 0; m2_ack = 0; m2_age = 0; m2_data = '0; m2_addr = '0;
    m2_wr = 0; m2_wdata = '0;
  endfunction

  function automatic void model_edge();
    logic [7:0] a1, a2;
    bit         op2, commit;
    commit = 0;
    m1_ack = 0;
    m2_ack = 0;
    if (reset) begin
      model_reset();
      return;
    end
    a1 = bus.address1[7:0];
    a2 = bus.address2[7:0];
    op2 = bus.writeM2;
    if (!bus.readM1) begin
      m1_act = 0; m1_done = 0;
    end else if (!m1_act || a1 != m1_addr) begin
      m1_act = 1; m1_done = 0; m1_addr = a1; m1_age = 0;
    end else if (!m1_done) begin
      m1_age++;
      if (m1_age == int'(LAT)) begin
        m1_done = 1; m1_ack = 1; m1_data = mmem[m1_addr];
      end
    end
    if (!(bus.readM2 || bus.writeM2)) begin
      m2_act = 0; m2_done = 0;
    end else if (!m2_act || a2 != m2_addr || op2 != m2_wr) begin
      m2_act = 1; m2_done = 0; m2_addr = a2; m2_wr = op2; m2_age = 0; m2_wdata = tb_wdata;
    end else if (!m2_done) begin
      m2_age++;
      if (m2_age == int'(LAT)) begin
        m2_done = 1; m2_ack = 1;
        if (m2_wr) commit = 1;
        else m2_data = mmem[m2_addr];
      end
    end
    // Port 1 has already sampled the old word above.
    if (commit) mmem[m2_addr] = m2_wdata;
  endfunction

  task automatic step();
    bit oe_exp;
    @(posedge clk);
    model_edge();
    #1;
    oe_exp = m2_done && !m2_wr && bus.readM2 && !bus.writeM2;
    check("ack1", 16'(bus.ack1), 16'(m1_ack));
    check("ack2", 16'(bus.ack2), 16'(m2_ack));
    check("data1", bus.data1, m1_data);
    check("data2_oe", 16'(bus.data2_oe), 16'(oe_exp));
    if (bus.data2_oe) check("data2", data2, m2_data);
  endtask

  // One full access: raise request, wait for ack (bounded), hold one cycle, drop.
  task automatic xact(input bit p2, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wd, output logic [15:0] rd, output int edges);
    logic got;
    edges = 0;
    rd    = '0;
    if (p2) begin
      bus.address2 = addr; bus.writeM2 = wr; bus.readM2 = !wr; tb_wdata = wd;
    end else begin
      bus.address1 = addr; bus.readM1 = 1'b1;
    end
    for (int i = 0; i < int'(LAT) + 6; i++) begin
      step();
      edges++;
      if (p2 && wr) check("oe_during_write", 16'(bus.data2_oe), 16'd0);
      got = p2 ? bus.ack2 : bus.ack1;
      if (got) begin
        rd = p2 ? data2 : bus.data1;
        break;
      end
    end
    step();
    check("ack_single_pulse", 16'(p2 ? bus.ack2 : bus.ack1), 16'd0);
    if (!p2) check("data1_held", bus.data1, rd);
    bus.readM1 = 1'b0; bus.readM2 = 1'b0; bus.writeM2 = 1'b0;
    step();
    if (!p2) check("data1_after_drop", bus.data1, rd);
  endtask

  typedef struct {
    bit          p2;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  function automatic logic [15:0] rnd_addr();
    return {8'($urandom), 4'h0, 4'($urandom)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [15:0] rd;
    int          edges;
    int unsigned r1, r2, k;
    logic        got1, got2;

    for (int i = 0; i < 256; i++) mmem[i] = '0;
    model_reset();
    reset = 1'b1;
    bus.readM1 = 0; bus.readM2 = 0; bus.writeM2 = 0;
    bus.address1 = '0; bus.address2 = '0; tb_wdata = '0;
    #12;
    check("reset_ack1", 16'(bus.ack1), 16'd0);
    check("reset_ack2", 16'(bus.ack2), 16'd0);
    check("reset_data1", bus.data1, 16'h0000);
    check("reset_data2_oe", 16'(bus.data2_oe), 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // Preload the random-traffic window 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      xact(1'b1, 1'b1, 16'(i), 16'hA000 + 16'(i * 17), rd, edges);
      check("preload_latency", 16'(edges), 16'(LAT + 1));
    end

    vecs.push_back('{1'b1, 1'b1, 16'h0010, 16'h1234, 16'h0000});
    vecs.push_back('{1'b1, 1'b1, 16'h0005, 16'h0505, 16'h0000});
    vecs.push_back('{1'b1, 1'b1, 16'h0006, 16'h0606, 16'h0000});
    vecs.push_back('{1'b1, 1'b1, 16'h0030, 16'h3030, 16'h0000});
    vecs.push_back('{1'b1, 1'b1, 16'h0040, 16'h0001, 16'h0000});
    vecs.push_back('{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234});
    vecs.push_back('{1'b0, 1'b0, 16'hFF10, 16'h0000, 16'h1234});
    vecs.push_back('{1'b1, 1'b1, 16'h0020, 16'hBEEF, 16'h0000});
    vecs.push_back('{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF});
    vecs.push_back('{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0505});
    vecs.push_back('{1'b1, 1'b0, 16'h0103, 16'h0000, 16'hA033});
    foreach (vecs[i]) begin
      xact(vecs[i].p2, vecs[i].wr, vecs[i].addr, vecs[i].wd, rd, edges);
      check("vec_latency", 16'(edges), 16'(LAT + 1));
      if (!vecs[i].wr) check("vec_read_data", rd, vecs[i].exp);
    end

    // Aborted write: 0x5555 to 0x30 dropped after two edges.
    bus.address2 = 16'h0030; bus.writeM2 = 1'b1; tb_wdata = 16'h5555;
    got2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      got2 = got2 | bus.ack2;
    end
    bus.writeM2 = 1'b0;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      step();
      got2 = got2 | bus.ack2;
    end
    check("abort_no_ack2", 16'(got2), 16'd0);
    xact(1'b1, 1'b0, 16'h0030, 16'h0000, rd, edges);
    check("abort_old_value", rd, 16'h3030);

    // Same-edge port-1 read and port-2 write to 0x40.
    bus.address1 = 16'h0040; bus.readM1 = 1'b1;
    bus.address2 = 16'h0040; bus.writeM2 = 1'b1; tb_wdata = 16'h00FF;
    edges = 0; got1 = 1'b0; got2 = 1'b0;
    for (int i = 0; i < int'(LAT) + 6; i++) begin
      step();
      edges++;
      got1 = bus.ack1; got2 = bus.ack2;
      if (got1 || got2) break;
    end
    check("collide_edges", 16'(edges), 16'(LAT + 1));
    check("collide_ack1", 16'(got1), 16'd1);
    check("collide_ack2", 16'(got2), 16'd1);
    check("collide_old_data", bus.data1, 16'h0001);
    bus.readM1 = 1'b0; bus.writeM2 = 1'b0;
    step();
    xact(1'b0, 1'b0, 16'h0040, 16'h0000, rd, edges);
    check("collide_new_data", rd, 16'h00FF);

    // Address change mid-BUSY restarts the count.
    bus.address1 = 16'h0005; bus.readM1 = 1'b1;
    step();
    step();
    bus.address1 = 16'h0006;
    edges = 0;
    for (int i = 0; i < int'(LAT) + 6; i++) begin
      step();
      edges++;
      if (bus.ack1) break;
    end
    check("restart_edges", 16'(edges), 16'(LAT + 1));
    check("restart_data", bus.data1, 16'h0606);
    bus.readM1 = 1'b0;
    step();

    // Reset in the middle of a write to 0x20.
    bus.address2 = 16'h0020; bus.writeM2 = 1'b1; tb_wdata = 16'h7777;
    step();
    step();
    reset = 1'b1;
    #1;
    check("midreset_ack2", 16'(bus.ack2), 16'd0);
    check("midreset_data1", bus.data1, 16'h0000);
    check("midreset_data2_oe", 16'(bus.data2_oe), 16'd0);
    model_reset();
    bus.writeM2 = 1'b0;
    step();
    @(negedge clk);
    reset = 1'b0;
    xact(1'b1, 1'b0, 16'h0020, 16'h0000, rd, edges);
    check("midreset_word_kept", rd, 16'hBEEF);
    check("midreset_first_latency", 16'(edges), 16'(LAT + 1));

    // Randomized traffic on both ports against the model.
    for (int c = 0; c < 1500; c++) begin
      r1 = $urandom_range(0, 99);
      r2 = $urandom_range(0, 99);
      if (!bus.readM1) begin
        if (r1 < 30) begin bus.readM1 = 1'b1; bus.address1 = rnd_addr(); end
      end else if (r1 < 6) bus.readM1 = 1'b0;
      else if (r1 < 10) bus.address1 = rnd_addr();
      if (!(bus.readM2 || bus.writeM2)) begin
        if (r2 < 30) begin
          k = $urandom_range(0, 2);
          bus.readM2 = (k != 1); bus.writeM2 = (k != 0); bus.address2 = rnd_addr();
        end
      end else if (r2 < 6) begin
        bus.readM2 = 1'b0; bus.writeM2 = 1'b0;
      end else if (r2 < 10) bus.address2 = rnd_addr();
      else if (r2 < 12) begin
        bus.writeM2 = !bus.writeM2; bus.readM2 = !bus.writeM2;
      end
      tb_wdata = 16'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
